// File: rtl/branch_target_buffer_pkg.sv
// -----------------------------------------------------------------------------
// branch_target_buffer_pkg
// Shared types for the IF-stage branch target buffer.
//   bpctr_t      : 2-bit saturating direction counter state
//   btb_entry_t  : one BTB line {valid, tag, target, ctr}
//   BTB_ENTRIES  : default number of BTB lines
// -----------------------------------------------------------------------------
package branch_target_buffer_pkg;

    localparam int BTB_ENTRIES = 16;

    // Tag field is sized for the smallest legal table (2 entries, 1 index bit).
    // Larger tables zero-extend their shorter tag into it; those upper bits
    // are constant and trim away in synthesis.
    localparam int BTB_TAG_W = 29;

    // Targets are word aligned, so only pc[31:2] is stored.
    localparam int BTB_TGT_W = 30;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bpctr_t;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [BTB_TGT_W-1:0] target;
        bpctr_t               ctr;
    } btb_entry_t;

    localparam btb_entry_t BTB_ENTRY_RESET = '{
        valid:  1'b0,
        tag:    '0,
        target: '0,
        ctr:    WEAK_NT
    };

endpackage

// File: rtl/branch_target_buffer_sat_counter2.sv
// -----------------------------------------------------------------------------
// sat_counter2
// Combinational next state of a 2-bit saturating direction counter.
//   i_ctr   : current counter state
//   i_taken : resolved branch outcome
//   o_ctr   : counter state after training (holds at STRONG_T / STRONG_NT)
// -----------------------------------------------------------------------------
module sat_counter2
    import branch_target_buffer_pkg::*;
(
    input  bpctr_t i_ctr,
    input  logic   i_taken,
    output bpctr_t o_ctr
);

    // NOTE: combinational blocks assign a default first so every path drives
    // the output and no latch is inferred.
    always_comb begin
        o_ctr = i_ctr;
        unique case (i_ctr)
            STRONG_NT: o_ctr = i_taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   o_ctr = i_taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    o_ctr = i_taken ? STRONG_T : WEAK_NT;
            STRONG_T:  o_ctr = i_taken ? STRONG_T : WEAK_T;
            default:   o_ctr = i_ctr;
        endcase
    end

endmodule

// File: rtl/branch_target_buffer.sv
// -----------------------------------------------------------------------------
// branch_target_buffer
// Direct-mapped BTB with 2-bit direction counters in the IF stage.
//   CLK, RST          : clock (rising edge), async active-high reset
//   fetch_pc          : PC being fetched this cycle
//   fetch_pc_plus     : fetch_pc + 4, the fall-through next PC
//   bp_hit            : entry valid, tag match and counter predicts taken
//   pred_npc          : predicted next PC (stored target on a hit)
//   upd_en            : EX resolved a conditional branch this cycle
//   upd_pc            : PC of the resolved branch
//   upd_taken         : actual direction
//   upd_target        : actual taken target
//   upd_pred          : bp_hit that travelled down the pipe with the branch
//   mispredict        : one-cycle pulse after a mispredicted update
//   mispred_cnt       : number of mispredictions (wraps)
//   branch_cnt        : number of updates (wraps)
// -----------------------------------------------------------------------------
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int ENTRIES = BTB_ENTRIES,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] fetch_pc_plus,
    output logic        bp_hit,
    output logic [31:0] pred_npc,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred,
    output logic        mispredict,
    output logic [31:0] mispred_cnt,
    output logic [31:0] branch_cnt
);

    localparam int TAG_W = 30 - IDX_W;

    btb_entry_t  r_table [ENTRIES];
    logic        r_mispredict;
    logic [31:0] r_mispred_cnt;
    logic [31:0] r_branch_cnt;

    function automatic logic [BTB_TAG_W-1:0] tag_of(input logic [31:0] pc);
        logic [BTB_TAG_W-1:0] t;
        t            = '0;
        t[TAG_W-1:0] = pc[31:IDX_W+2];
        return t;
    endfunction

    // ---------------- lookup (combinational, reads pre-update contents) -----
    logic [IDX_W-1:0] w_fetch_idx;
    btb_entry_t       w_fetch_entry;
    logic             w_fetch_hit;

    assign w_fetch_idx   = fetch_pc[IDX_W+1:2];
    assign w_fetch_entry = r_table[w_fetch_idx];
    // RST gating keeps the outputs quiet while reset is held, independent of
    // how the table flops settle.
    assign w_fetch_hit   = ~RST & w_fetch_entry.valid
                         & (w_fetch_entry.tag == tag_of(fetch_pc))
                         & w_fetch_entry.ctr[1];

    assign bp_hit   = w_fetch_hit;
    assign pred_npc = w_fetch_hit ? {w_fetch_entry.target, 2'b00} : fetch_pc_plus;

    // ---------------- update path ------------------------------------------
    logic [IDX_W-1:0] w_upd_idx;
    btb_entry_t       w_upd_entry;
    logic             w_upd_match;
    bpctr_t           w_ctr_next;
    btb_entry_t       w_new_entry;
    logic             w_write;
    logic             w_mispred;

    assign w_upd_idx   = upd_pc[IDX_W+1:2];
    assign w_upd_entry = r_table[w_upd_idx];
    assign w_upd_match = w_upd_entry.valid & (w_upd_entry.tag == tag_of(upd_pc));

    sat_counter2 u_sat_counter2 (
        .i_ctr   (w_upd_entry.ctr),
        .i_taken (upd_taken),
        .o_ctr   (w_ctr_next)
    );

    // Predicted target is whatever the line holds now, before this write.
    assign w_mispred = (upd_pred != upd_taken)
                     | (upd_pred & upd_taken
                        & ({w_upd_entry.target, 2'b00} != upd_target));

    always_comb begin
        w_new_entry = w_upd_entry;
        w_write     = 1'b0;
        if (w_upd_match) begin
            w_write         = 1'b1;
            w_new_entry.ctr = w_ctr_next;
            if (upd_taken) begin
                w_new_entry.target = upd_target[31:2];
            end
        end else if (upd_taken) begin
            // Allocate or replace; a not-taken miss never allocates.
            w_write            = 1'b1;
            w_new_entry.valid  = 1'b1;
            w_new_entry.tag    = tag_of(upd_pc);
            w_new_entry.target = upd_target[31:2];
            w_new_entry.ctr    = WEAK_T;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // NOTE: the table is a flop array that must come up invalid, so it is
    // reset explicitly; it cannot be mapped to a RAM macro without reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= BTB_ENTRY_RESET;
            end
            r_mispredict  <= 1'b0;
            r_mispred_cnt <= '0;
            r_branch_cnt  <= '0;
        end else begin
            r_mispredict <= 1'b0;
            // Everything below is gated by upd_en, so X on upd_* is harmless
            // while no update is requested.
            if (upd_en) begin
                if (w_write) begin
                    r_table[w_upd_idx] <= w_new_entry;
                end
                r_mispredict <= w_mispred;
                if (w_mispred) begin
                    r_mispred_cnt <= r_mispred_cnt + 32'd1;
                end
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
        end
    end

    assign mispredict  = r_mispredict;
    assign mispred_cnt = r_mispred_cnt;
    assign branch_cnt  = r_branch_cnt;

    // Byte-offset bits and the lookup counter's low bit do not affect results.
    logic w_unused;
    assign w_unused = ^{fetch_pc[1:0], upd_pc[1:0], w_fetch_entry.ctr[0]};

endmodule

// File: tb/tb_branch_target_buffer.sv
// -----------------------------------------------------------------------------
// tb_branch_target_buffer
// Table-driven directed bench for branch_target_buffer (ENTRIES = 16).
// Each vector is driven on the falling edge; lookup outputs are compared
// before the rising edge (pre-update view), registered outputs just after it.
// -----------------------------------------------------------------------------
module tb_branch_target_buffer;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_plus;
    logic        bp_hit;
    logic [31:0] pred_npc;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred;
    logic        mispredict;
    logic [31:0] mispred_cnt;
    logic [31:0] branch_cnt;

    int checks = 0;
    int errors = 0;

    branch_target_buffer #(.ENTRIES(16)) dut (
        .CLK           (clk),
        .RST           (rst),
        .fetch_pc      (fetch_pc),
        .fetch_pc_plus (fetch_pc_plus),
        .bp_hit        (bp_hit),
        .pred_npc      (pred_npc),
        .upd_en        (upd_en),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .upd_pred      (upd_pred),
        .mispredict    (mispredict),
        .mispred_cnt   (mispred_cnt),
        .branch_cnt    (branch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fetch_pc_plus = fetch_pc + 32'd4;

    typedef struct {
        logic        en;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic        pred;
        logic [31:0] fpc;
        logic        exp_hit;
        logic [31:0] exp_npc;
        logic        exp_mp;
        logic [31:0] exp_mc;
        logic [31:0] exp_bc;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic en, input logic [31:0] pc,
                                input logic taken, input logic [31:0] target,
                                input logic pred, input logic [31:0] fpc,
                                input logic exp_hit, input logic [31:0] exp_npc,
                                input logic exp_mp, input logic [31:0] exp_mc,
                                input logic [31:0] exp_bc);
        vec_t v;
        v.en = en; v.pc = pc; v.taken = taken; v.target = target; v.pred = pred;
        v.fpc = fpc; v.exp_hit = exp_hit; v.exp_npc = exp_npc;
        v.exp_mp = exp_mp; v.exp_mc = exp_mc; v.exp_bc = exp_bc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        upd_en     = 1'b0;
        upd_pc     = '0;
        upd_taken  = 1'b0;
        upd_target = '0;
        upd_pred   = 1'b0;
    endtask

    initial begin
        //            en  pc           tk  target       pr  fetch_pc     hit npc          mp mc  bc
        vecs[0]  = mk(0, 32'h0,       0, 32'h0,       0, 32'h40,      0, 32'h44,      0, 0,  0);
        // first allocation, lookup same index same cycle sees the old (empty) line
        vecs[1]  = mk(1, 32'h40,      1, 32'h100,     0, 32'h40,      0, 32'h44,      1, 1,  1);
        vecs[2]  = mk(0, 32'h0,       0, 32'h0,       0, 32'h40,      1, 32'h100,     0, 1,  1);
        // climb to STRONG_T and hold there
        vecs[3]  = mk(1, 32'h40,      1, 32'h100,     1, 32'h40,      1, 32'h100,     0, 1,  2);
        vecs[4]  = mk(1, 32'h40,      1, 32'h100,     1, 32'h40,      1, 32'h100,     0, 1,  3);
        // two not-taken: 11 -> 10 -> 01
        vecs[5]  = mk(1, 32'h40,      0, 32'h0,       1, 32'h40,      1, 32'h100,     1, 2,  4);
        vecs[6]  = mk(1, 32'h40,      0, 32'h0,       1, 32'h40,      1, 32'h100,     1, 3,  5);
        vecs[7]  = mk(0, 32'h0,       0, 32'h0,       0, 32'h40,      0, 32'h44,      0, 3,  5);
        // 01 -> 00, then stays 00
        vecs[8]  = mk(1, 32'h40,      0, 32'h0,       0, 32'h40,      0, 32'h44,      0, 3,  6);
        vecs[9]  = mk(1, 32'h40,      0, 32'h0,       0, 32'h40,      0, 32'h44,      0, 3,  7);
        // 00 -> 01 (still not-taken prediction)
        vecs[10] = mk(1, 32'h40,      1, 32'h100,     0, 32'h40,      0, 32'h44,      1, 4,  8);
        vecs[11] = mk(0, 32'h0,       0, 32'h0,       0, 32'h40,      0, 32'h44,      0, 4,  8);
        // 01 -> 10 with a new target
        vecs[12] = mk(1, 32'h40,      1, 32'h104,     0, 32'h40,      0, 32'h44,      1, 5,  9);
        vecs[13] = mk(0, 32'h0,       0, 32'h0,       0, 32'h40,      1, 32'h104,     0, 5,  9);
        // predicted taken, taken, but to a different target
        vecs[14] = mk(1, 32'h40,      1, 32'h108,     1, 32'h40,      1, 32'h104,     1, 6,  10);
        vecs[15] = mk(0, 32'h0,       0, 32'h0,       0, 32'h40,      1, 32'h108,     0, 6,  10);
        // aliasing: 0x80 replaces 0x40 at index 0
        vecs[16] = mk(1, 32'h80,      1, 32'h200,     0, 32'h80,      0, 32'h84,      1, 7,  11);
        vecs[17] = mk(0, 32'h0,       0, 32'h0,       0, 32'h40,      0, 32'h44,      0, 7,  11);
        vecs[18] = mk(0, 32'h0,       0, 32'h0,       0, 32'h80,      1, 32'h200,     0, 7,  11);
        // not-taken miss does not allocate
        vecs[19] = mk(1, 32'h44,      0, 32'h0,       0, 32'h44,      0, 32'h48,      0, 7,  12);
        // X on update fields while disabled must be ignored
        vecs[20] = mk(0, 32'hx,       1'bx, 32'hx,    1'bx, 32'h44,   0, 32'h48,      0, 7,  12);
        vecs[21] = mk(0, 32'h0,       0, 32'h0,       0, 32'h80,      1, 32'h200,     0, 7,  12);
        // upper tag bits differ, same index
        vecs[22] = mk(0, 32'h0,       0, 32'h0,       0, 32'h1000_0080, 0, 32'h1000_0084, 0, 7, 12);
        // correct taken prediction with matching target
        vecs[23] = mk(1, 32'h80,      1, 32'h200,     1, 32'h80,      1, 32'h200,     0, 7,  13);

        // ---------------- reset state ----------------
        rst      = 1'b1;
        fetch_pc = 32'h40;
        idle_inputs();
        repeat (2) @(negedge clk);
        check("reset bp_hit",      {31'b0, bp_hit}, 32'h0);
        check("reset pred_npc",    pred_npc, 32'h44);
        check("reset mispredict",  {31'b0, mispredict}, 32'h0);
        check("reset mispred_cnt", mispred_cnt, 32'h0);
        check("reset branch_cnt",  branch_cnt, 32'h0);
        rst = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            upd_en     = vecs[i].en;
            upd_pc     = vecs[i].pc;
            upd_taken  = vecs[i].taken;
            upd_target = vecs[i].target;
            upd_pred   = vecs[i].pred;
            fetch_pc   = vecs[i].fpc;
            #1;
            check($sformatf("v%0d bp_hit", i),   {31'b0, bp_hit}, {31'b0, vecs[i].exp_hit});
            check($sformatf("v%0d pred_npc", i), pred_npc, vecs[i].exp_npc);
            @(posedge clk);
            #1;
            check($sformatf("v%0d mispredict", i),  {31'b0, mispredict}, {31'b0, vecs[i].exp_mp});
            check($sformatf("v%0d mispred_cnt", i), mispred_cnt, vecs[i].exp_mc);
            check($sformatf("v%0d branch_cnt", i),  branch_cnt, vecs[i].exp_bc);
        end

        // ---------------- asynchronous reset mid-stream ----------------
        @(negedge clk);
        idle_inputs();
        fetch_pc = 32'h80;
        #1;
        check("pre-rst bp_hit", {31'b0, bp_hit}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("async rst bp_hit",      {31'b0, bp_hit}, 32'h0);
        check("async rst pred_npc",    pred_npc, 32'h84);
        check("async rst mispred_cnt", mispred_cnt, 32'h0);
        check("async rst branch_cnt",  branch_cnt, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // not-taken update at a fresh pc: counted, no allocation, no mispredict
        @(negedge clk);
        upd_en     = 1'b1;
        upd_pc     = 32'h300;
        upd_taken  = 1'b0;
        upd_target = 32'h0;
        upd_pred   = 1'b0;
        fetch_pc   = 32'h300;
        @(posedge clk);
        #1;
        check("post-rst mispredict",  {31'b0, mispredict}, 32'h0);
        check("post-rst mispred_cnt", mispred_cnt, 32'h0);
        check("post-rst branch_cnt",  branch_cnt, 32'h1);
        @(negedge clk);
        idle_inputs();
        #1;
        check("post-rst 0x300 bp_hit",   {31'b0, bp_hit}, 32'h0);
        check("post-rst 0x300 pred_npc", pred_npc, 32'h304);
        fetch_pc = 32'h80;
        #1;
        check("post-rst 0x80 bp_hit",   {31'b0, bp_hit}, 32'h0);
        check("post-rst 0x80 pred_npc", pred_npc, 32'h84);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Direct-mapped branch target buffer with 2-bit saturating direction counters, sitting in the IF stage directly upstream of the IF|ID latch.
- Looks up the current fetch PC combinationally and drives the predicted next PC plus the bp_hit bit carried in ifid_t.
- Trained one cycle after resolution by the EX stage, using the bp_hit/cpc/pc_plus fields carried in idex_t.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, at least 2.
- IDX_W, $clog2(ENTRIES), index width; the index is pc[IDX_W+1:2].

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- fetch_pc  in  32  current PC (word_t).
- fetch_pc_plus  in  32  fetch_pc + 4.
- bp_hit  out  1  valid entry, tag match, and counter[1]==1 (predict taken).
- pred_npc  out  32  target when bp_hit, else fetch_pc_plus.
- upd_en  in  1  EX resolved a BrEq/BrNeq this cycle (qualified by no EX flush).
- upd_pc  in  32  cpc of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  32  actual taken target.
- upd_pred  in  1  bp_hit value that travelled with the branch.
- mispredict  out  1  registered; pulses for one cycle when the last update mispredicted.
- mispred_cnt  out  32  count of mispredictions, wraps at 2^32.
- branch_cnt  out  32  count of updates, wraps.

Behaviour:
- Storage per entry: valid (1), tag (pc[31:IDX_W+2]), target (30 bits, word aligned), ctr (2 bits).
- Lookup is purely combinational, with no added latency.
  - bp_hit = valid[i] & (tag[i]==fetch_pc tag) & ctr[i][1].
  - pred_npc = {target[i],2'b00} when bp_hit, else fetch_pc_plus.
- Update is sequential on the rising CLK edge when upd_en=1; j is the upd_pc index.
  - Tag match & valid, taken: ctr = sat_inc(ctr), i.e. 00->01->10->11, holding at 11; target <= upd_target.
  - Tag match & valid, not taken: ctr = sat_dec, holding at 00; target unchanged.
  - Miss (invalid or tag mismatch), taken: allocate or replace; valid=1, tag=new, target=upd_target, ctr=2'b10 (weakly taken).
  - Miss, not taken: no change (no allocation).
- Misprediction
  - Defined as upd_pred != upd_taken, or (upd_pred & upd_taken & predicted target != upd_target).
  - Predicted target is the stored target read at index j before the write.
  - On misprediction: mispredict=1 on the next cycle and mispred_cnt increments. branch_cnt increments on every upd_en.
- Lookup and update on the same index in the same cycle: lookup returns the pre-update contents (read-old). The new value is visible on the following cycle.
- Stalls: this block has no stall input. A held fetch_pc gives a stable lookup; the PC register owner handles stalls.
- Reset (asynchronous, whenever RST=1, including mid-operation):
  - all valid=0, ctr=01, tag/target=0;
  - mispredict=0, mispred_cnt=0, branch_cnt=0.
  - Outputs during reset: bp_hit=0, pred_npc=fetch_pc_plus.
- An X on upd_* while upd_en=0 must not alter state.

Decomposition:
- The shared package (the aww types package) gets:
  - btb_entry_t, a packed struct {valid, tag, target, ctr};
  - bpctr_t, a 2-bit enum (STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11);
  - BTB_ENTRIES as a constant.
- Sub-module sat_counter2: combinational next-state for bpctr_t given taken, instantiated once on the update path.

Test Plan:
- Reset, then fetch_pc=0x40 -> bp_hit=0, pred_npc=0x44, all counts 0.
- Update pc=0x40, taken, target=0x100, upd_pred=0 -> next cycle mispredict=1, mispred_cnt=1, branch_cnt=1; lookup 0x40 -> bp_hit=1, pred_npc=0x100.
- Saturation: three taken updates at 0x40 reach ctr=11. Two not-taken updates -> ctr=01, bp_hit=0 at lookup. Further not-taken -> 00; a further one stays 00.
- Aliasing (ENTRIES=16): pc 0x40 and 0x80 share an index. A taken update at 0x80 (target 0x200) replaces the entry; lookup 0x40 -> bp_hit=0, lookup 0x80 -> pred_npc=0x200.
- Same-cycle lookup and update on 0x40 (first allocation) -> bp_hit=0 that cycle, 1 the next.
- RST asserted mid-stream, asynchronously between edges -> bp_hit drops to 0 immediately, counters 0. Not-taken update at a new pc -> no allocation, branch_cnt=1, mispredict=0.
